data_mem_ctrl: RTL

Memory-stage access controller between the ALU_MEM pipeline register and the data RAM. Turns each chip-selected load/store presented by ALU_MEM into a req/ack transaction on a multi-cycle data memory, generates byte enables and store-data lane replication, and formats load data (shift, sign/zero extend) for MEM_WB. Holds the pipeline with a stall while an access is outstanding, and reports misaligned, illegal-op and ack-timeout errors.

---
 rtl/data_mem_ctrl_pkg.sv | 77 +++++++
 rtl/mem_load_format.sv | 42 ++++
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: control-bus
// layout, funct3 encodings, FSM state codes and store-path helper functions.
package data_mem_ctrl_pkg;

    localparam int CTRL_W = 4;   // {is_store, funct3}
    localparam int DATA_W = 32;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Stores accept B/H/W only; loads additionally accept BU/HU.
    function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
        logic ok;
        ok = 1'b0;
        if (ctrl[3]) begin
            case (ctrl[2:0])
                F3_B, F3_H, F3_W: ok = 1'b1;
                default:          ok = 1'b0;
            endcase
        end else begin
            case (ctrl[2:0])
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Size is carried in funct3[1:0]; the unsigned bit does not affect alignment.
    function automatic logic addr_is_aligned(input logic [2:0] funct3, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lo[0] == 1'b0);
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store data across every lane so the RAM picks the enabled one.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] funct3,
                                                      input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] lanes;
        lanes = 32'h0000_0000;
        case (funct3)
            F3_B:    lanes = {4{wd[7:0]}};
            F3_H:    lanes = {2{wd[15:0]}};
            F3_W:    lanes = wd;
            default: lanes = 32'h0000_0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_format.sv
// Load-data formatter: picks the addressed byte/half out of the RAM word and
// sign- or zero-extends it according to funct3.
module mem_load_format
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the loaded value
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;
        case (addr)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_W:    result = word;
            F3_BU:   result = {24'h00_0000, byte_s};
            F3_HU:   result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage access controller: converts ALU_MEM load/store requests into
// req/ack transactions on the data RAM, stalls the pipeline while an access
// is outstanding and formats load data for MEM_WB.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              reqValid,
    input  logic [CTRL_W-1:0] reqControl,
    input  logic [DATA_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              stallOut,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic [3:0]        memByteEn,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic [DATA_W-1:0] loadData,
    output logic              loadValid,
    output logic              misalignOut,
    output logic              errorOut
);

    localparam int          CNT_W      = 16;
    localparam logic [15:0] TIMEOUT_LIM = 16'(ACK_TIMEOUT);
    localparam logic        TIMEOUT_EN = (ACK_TIMEOUT != 0);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [1:0]        addr_lo_r;
    logic              mem_req_r, mem_we_r, load_valid_r, misalign_r, error_r;
    logic [DATA_W-1:0] mem_addr_r, mem_wdata_r, load_data_r;
    logic [3:0]        mem_be_r;

    logic              legal_s, aligned_s, accept_s, timeout_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [DATA_W-1:0] fmt_s;

    assign legal_s    = ctrl_is_legal(reqControl);
    assign aligned_s  = addr_is_aligned(reqControl[2:0], reqAddr[1:0]);
    assign accept_s   = (state_r == ST_IDLE) && reqValid && legal_s && aligned_s;
    assign cnt_next_s = cnt_r + 16'd1;
    // Abort on the REQ cycle that would bring the wait count up to the limit.
    assign timeout_s  = TIMEOUT_EN && (cnt_next_s == TIMEOUT_LIM);

    // Stall must react in the accept cycle itself, so it is decoded from state and inputs.
    assign stallOut = accept_s || (state_r == ST_REQ);

    mem_load_format u_fmt (
        .funct3 (ctrl_r[2:0]),
        .addr   (addr_lo_r),
        .word   (memRData),
        .result (fmt_s)
    );

    // Access FSM with registered RAM-side and pipeline-side outputs
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            ctrl_r       <= 4'h0;
            addr_lo_r    <= 2'b00;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_be_r     <= 4'b0000;
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
            error_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (reqValid && !legal_s) begin
                        error_r <= 1'b1;
                    end else if (reqValid && !aligned_s) begin
                        misalign_r <= 1'b1;
                    end else if (accept_s) begin
                        state_r     <= ST_REQ;
                        cnt_r       <= 16'd0;
                        ctrl_r      <= reqControl;
                        addr_lo_r   <= reqAddr[1:0];
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= reqControl[3];
                        mem_addr_r  <= {reqAddr[31:2], 2'b00};
                        mem_wdata_r <= store_lanes(reqControl[2:0], reqWData);
                        mem_be_r    <= reqControl[3] ? store_byte_en(reqControl[2:0], reqAddr[1:0])
                                                     : 4'b0000;
                    end
                end
                ST_REQ: begin
                    if (memAck) begin
                        state_r   <= ST_DONE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (!ctrl_r[3]) begin
                            load_valid_r <= 1'b1;
                            load_data_r  <= fmt_s;
                        end
                    end else if (timeout_s) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        error_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign memReq      = mem_req_r;
    assign memWe       = mem_we_r;
    assign memAddr     = mem_addr_r;
    assign memWData    = mem_wdata_r;
    assign memByteEn   = mem_be_r;
    assign loadData    = load_data_r;
    assign loadValid   = load_valid_r;
    assign misalignOut = misalign_r;
    assign errorOut    = error_r;

endmodule
